// File: rtl/fifo_defs.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_defs (package)
//  Description : Definitions shared by the FIFO family: read-mode constants
//                and the almost-full / almost-empty threshold range check.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_defs;

    // Values accepted by the SHOW_AHEAD parameter of every FIFO variant
    localparam int FIFO_MODE_NORMAL    = 0;
    localparam int FIFO_MODE_SHOWAHEAD = 1;

    // True when both thresholds lie inside the range the flag logic supports
    function automatic bit thresh_ok(int depth, int af_thresh, int ae_thresh);
        return (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_flags_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flags_pkg (package)
//  Description : Types and helpers for the single-clock flagged FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package sync_fifo_flags_pkg;

    // Read-port style of the storage array
    typedef enum logic {
        RAM_READ_REG   = 1'b0,
        RAM_READ_ASYNC = 1'b1
    } ram_read_e;

    // Occupancy-derived status flags, registered together
    typedef struct packed {
        logic wrfull;
        logic rdempty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Status flags for a given word count
    function automatic fifo_flags_t flags_from_count(int count, int depth,
                                                     int af_thresh, int ae_thresh);
        fifo_flags_t f;
        f.wrfull       = (count >= depth);
        f.rdempty      = (count == 0);
        f.almost_full  = (count >= af_thresh);
        f.almost_empty = (count <= ae_thresh);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_flags_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flags_if
//  Description : Write/read/status bundle of the single-clock flagged FIFO.
//                master = FIFO user, slave = FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     sclr;
    logic [DATA_WIDTH-1:0]    data;
    logic                     wrreq;
    logic                     wrfull;
    logic [DATA_WIDTH-1:0]    q;
    logic                     rdreq;
    logic                     rdempty;
    logic [ADDRESS_WIDTH:0]   usedw;
    logic                     almost_full;
    logic                     almost_empty;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output sclr, data, wrreq, rdreq,
        input  wrfull, q, rdempty, usedw, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  sclr, data, wrreq, rdreq,
        output wrfull, q, rdempty, usedw, almost_full, almost_empty,
               overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_flags_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_ram
//  Description : Simple dual-port storage: one write port, one read port.
//                Read is either registered (enable-gated) or asynchronous.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_ram
    import sync_fifo_flags_pkg::*;
#(
    parameter int        DATA_WIDTH    = 8,
    parameter int        ADDRESS_WIDTH = 4,
    parameter ram_read_e READ_MODE     = RAM_READ_REG
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     we,
    input  wire logic [ADDRESS_WIDTH-1:0] waddr,
    input  wire logic [DATA_WIDTH-1:0]    wdata,
    input  wire logic                     re,
    input  wire logic [ADDRESS_WIDTH-1:0] raddr,
    output logic      [DATA_WIDTH-1:0]    rdata
);
    localparam int c_words = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:c_words-1];

    // Storage write; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    generate
        if (READ_MODE == RAM_READ_REG) begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rdata;

            // Output register loads only on an enabled read, else holds
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (re) begin
                    r_rdata <= r_mem[raddr];
                end
            end

            assign rdata = r_rdata;
        end else begin : g_async_read
            // Read enable and reset have no role when the array is read directly
            logic w_unused_ctrl;
            assign w_unused_ctrl = &{1'b0, re, rst_n};
            assign rdata         = r_mem[raddr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flags
//  Description : Single-clock FIFO with fill count, almost-full/almost-empty
//                thresholds, sticky overflow/underflow and synchronous clear.
//                Normal (registered q) or show-ahead read mode.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH,
    parameter int SHOW_AHEAD    = 0,
    parameter int AF_THRESH     = FIFO_DEPTH - 2,
    parameter int AE_THRESH     = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sync_fifo_flags_if.slave  bus
);
    localparam ram_read_e c_read_mode =
        (SHOW_AHEAD == fifo_defs::FIFO_MODE_SHOWAHEAD) ? RAM_READ_ASYNC : RAM_READ_REG;
    localparam fifo_flags_t c_flags_rst = '{wrfull: 1'b0, rdempty: 1'b1,
                                            almost_full: 1'b0, almost_empty: 1'b1};

    // Elaboration-time parameter legality
    generate
        if (ADDRESS_WIDTH < 2) begin : g_bad_address_width
            $error("sync_fifo_flags: ADDRESS_WIDTH must be >= 2");
        end
        if (FIFO_DEPTH != (1 << ADDRESS_WIDTH)) begin : g_bad_depth
            $error("sync_fifo_flags: FIFO_DEPTH is derived from ADDRESS_WIDTH");
        end
        if ((SHOW_AHEAD != fifo_defs::FIFO_MODE_NORMAL) &&
            (SHOW_AHEAD != fifo_defs::FIFO_MODE_SHOWAHEAD)) begin : g_bad_mode
            $error("sync_fifo_flags: SHOW_AHEAD must be 0 or 1");
        end
        if (!fifo_defs::thresh_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
            $error("sync_fifo_flags: AF_THRESH/AE_THRESH out of range");
        end
    endgenerate

    // Pointers carry one wrap bit above the address so full and empty differ
    logic [ADDRESS_WIDTH:0]  r_wr_ptr;
    logic [ADDRESS_WIDTH:0]  r_rd_ptr;
    logic [ADDRESS_WIDTH:0]  w_wr_ptr_nxt;
    logic [ADDRESS_WIDTH:0]  w_rd_ptr_nxt;
    logic [ADDRESS_WIDTH:0]  w_count_nxt;
    fifo_flags_t             r_flags;
    fifo_flags_t             w_flags_nxt;
    logic                    r_overflow;
    logic                    r_underflow;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic [DATA_WIDTH-1:0]   w_rdata;

    // Acceptance judged only on registered flags; clear overrides both requests
    assign w_wr_acc = bus.wrreq & ~r_flags.wrfull  & ~bus.sclr;
    assign w_rd_acc = bus.rdreq & ~r_flags.rdempty & ~bus.sclr;

    assign w_wr_ptr_nxt = bus.sclr ? '0 : r_wr_ptr + {{ADDRESS_WIDTH{1'b0}}, w_wr_acc};
    assign w_rd_ptr_nxt = bus.sclr ? '0 : r_rd_ptr + {{ADDRESS_WIDTH{1'b0}}, w_rd_acc};

    // Modular pointer difference is the word count, 0..FIFO_DEPTH
    assign w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_flags_nxt = flags_from_count(int'(w_count_nxt), FIFO_DEPTH,
                                          AF_THRESH, AE_THRESH);

    // Pointer and flag state; flags track the count on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_flags  <= c_flags_rst;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_flags  <= w_flags_nxt;
        end
    end

    // Sticky error flags, cleared only by reset or sclr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.sclr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wrreq && r_flags.wrfull) begin
                r_overflow <= 1'b1;
            end
            if (bus.rdreq && r_flags.rdempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .READ_MODE     (c_read_mode)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr[ADDRESS_WIDTH-1:0]),
        .wdata (bus.data),
        .re    (w_rd_acc),
        .raddr (r_rd_ptr[ADDRESS_WIDTH-1:0]),
        .rdata (w_rdata)
    );

    generate
        if (SHOW_AHEAD == fifo_defs::FIFO_MODE_SHOWAHEAD) begin : g_show_ahead
            // Head word falls through; forced to zero while empty so reset q is 0
            assign bus.q = r_flags.rdempty ? '0 : w_rdata;
        end else begin : g_normal
            assign bus.q = w_rdata;
        end
    endgenerate

    assign bus.usedw        = r_wr_ptr - r_rd_ptr;
    assign bus.wrfull       = r_flags.wrfull;
    assign bus.rdempty      = r_flags.rdempty;
    assign bus.almost_full  = r_flags.almost_full;
    assign bus.almost_empty = r_flags.almost_empty;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_flags
//  Description : Self-checking bench: normal-mode and show-ahead instances,
//                vector table, directed corner sequences, randomized traffic
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_flags;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_a ();
    sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_b ();

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH),
        .SHOW_AHEAD(0), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH),
        .SHOW_AHEAD(1), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: contents as a queue, q as last popped word
    logic [7:0] mq[$];
    logic [7:0] m_q;
    bit         m_ovf;
    bit         m_udf;

    typedef struct {
        bit          s;
        bit          w;
        bit          r;
        logic [7:0]  d;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [18:0] pk(int u, bit f, bit e, bit af, bit ae,
                                       bit o, bit un, logic [7:0] qv);
        return {u[4:0], f, e, af, ae, o, un, qv};
    endfunction

    function automatic logic [18:0] model_pack();
        int sz = mq.size();
        return pk(sz, sz == DEPTH, sz == 0, sz >= AF, sz <= AE, m_ovf, m_udf, m_q);
    endfunction

    function automatic logic [18:0] dut_a_pack();
        return {bus_a.usedw, bus_a.wrfull, bus_a.rdempty, bus_a.almost_full,
                bus_a.almost_empty, bus_a.overflow, bus_a.underflow, bus_a.q};
    endfunction

    function automatic logic [18:0] dut_b_pack();
        return {bus_b.usedw, bus_b.wrfull, bus_b.rdempty, bus_b.almost_full,
                bus_b.almost_empty, bus_b.overflow, bus_b.underflow, bus_b.q};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_q   = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(bit s, bit w, bit r, logic [7:0] d);
        bit full;
        bit empty;
        if (s) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            if (w && full)   m_ovf = 1'b1;
            if (r && empty)  m_udf = 1'b1;
            if (r && !empty) m_q = mq.pop_front();
            if (w && !full)  mq.push_back(d);
        end
    endtask

    // One clock on the normal-mode FIFO, optionally compared with the model
    task automatic cyc_a(bit s, bit w, bit r, logic [7:0] d, bit chk);
        bus_a.sclr  = s;
        bus_a.wrreq = w;
        bus_a.rdreq = r;
        bus_a.data  = d;
        model_step(s, w, r, d);
        @(posedge clk);
        #1;
        bus_a.sclr  = 1'b0;
        bus_a.wrreq = 1'b0;
        bus_a.rdreq = 1'b0;
        if (chk) check("model", dut_a_pack(), model_pack());
    endtask

    task automatic cyc_b(bit w, bit r, logic [7:0] d);
        bus_b.wrreq = w;
        bus_b.rdreq = r;
        bus_b.data  = d;
        @(posedge clk);
        #1;
        bus_b.wrreq = 1'b0;
        bus_b.rdreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wval;
        logic [7:0] rval;
        bit         w;
        bit         r;
        bit         s;

        // Empty+both, simultaneous at occupancy, sclr with pending write
        tbl[0] = '{0, 1, 1, 8'h11, pk(1, 0, 0, 0, 1, 0, 1, 8'h00)};
        tbl[1] = '{0, 1, 0, 8'h22, pk(2, 0, 0, 0, 1, 0, 1, 8'h00)};
        tbl[2] = '{0, 1, 0, 8'h33, pk(3, 0, 0, 0, 0, 0, 1, 8'h00)};
        tbl[3] = '{0, 0, 1, 8'h00, pk(2, 0, 0, 0, 1, 0, 1, 8'h11)};
        tbl[4] = '{0, 1, 1, 8'h44, pk(2, 0, 0, 0, 1, 0, 1, 8'h22)};
        tbl[5] = '{1, 1, 0, 8'h55, pk(0, 0, 1, 0, 1, 0, 0, 8'h22)};
        tbl[6] = '{0, 0, 1, 8'h00, pk(0, 0, 1, 0, 1, 0, 1, 8'h22)};
        tbl[7] = '{0, 1, 0, 8'h66, pk(1, 0, 0, 0, 1, 0, 1, 8'h22)};
        tbl[8] = '{0, 0, 1, 8'h00, pk(0, 0, 1, 0, 1, 0, 1, 8'h66)};

        rst_n = 1'b0;
        bus_a.sclr = 1'b0; bus_a.wrreq = 1'b0; bus_a.rdreq = 1'b0; bus_a.data = '0;
        bus_b.sclr = 1'b0; bus_b.wrreq = 1'b0; bus_b.rdreq = 1'b0; bus_b.data = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_a", dut_a_pack(), pk(0, 0, 1, 0, 1, 0, 0, 8'h00));
        check("reset_b", dut_b_pack(), pk(0, 0, 1, 0, 1, 0, 0, 8'h00));
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 9; i++) begin
            cyc_a(tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].d, 1'b0);
            check($sformatf("vec%0d", i), dut_a_pack(), tbl[i].exp);
        end

        // Fill 0x00..0x0F, then overflow, then both requests at full, then drain
        for (int i = 0; i < DEPTH; i++) begin
            cyc_a(0, 1, 0, 8'(i), 1);
            check("fill_af", bus_a.almost_full, (i + 1) >= AF);
            check("fill_full", bus_a.wrfull, (i + 1) == DEPTH);
        end
        cyc_a(0, 1, 0, 8'hEE, 1);
        check("ovf_usedw", bus_a.usedw, 16);
        check("ovf_flag", bus_a.overflow, 1);
        cyc_a(0, 1, 1, 8'hDD, 1);
        check("full_both_usedw", bus_a.usedw, 15);
        check("full_both_ovf", bus_a.overflow, 1);
        check("full_both_q", bus_a.q, 8'h00);
        for (int i = 1; i < DEPTH; i++) begin
            cyc_a(0, 0, 1, 8'h00, 1);
            check("drain_q", bus_a.q, i);
        end
        check("drained", bus_a.rdempty, 1);

        // Wrap-around at constant occupancy 3
        wval = 8'h30;
        rval = 8'h30;
        for (int i = 0; i < 3; i++) begin
            cyc_a(0, 1, 0, wval, 1);
            wval++;
        end
        for (int i = 0; i < 40; i++) begin
            cyc_a(0, 1, 1, wval, 1);
            wval++;
            check("wrap_q", bus_a.q, rval);
            check("wrap_usedw", bus_a.usedw, 3);
            rval++;
        end
        for (int i = 0; i < 3; i++) begin
            cyc_a(0, 0, 1, 8'h00, 1);
            check("wrap_tail_q", bus_a.q, rval);
            rval++;
        end

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++) cyc_a(0, 1, 0, 8'(8'h80 + i), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_a_pack(), pk(0, 0, 1, 0, 1, 0, 0, 8'h00));
        model_reset();
        #1;
        rst_n = 1'b1;
        cyc_a(0, 0, 1, 8'h00, 1);
        check("post_reset_udf", bus_a.underflow, 1);

        // sclr with a pending write at usedw=9 and overflow set
        for (int i = 0; i < DEPTH; i++) cyc_a(0, 1, 0, 8'(8'hC0 + i), 1);
        cyc_a(0, 1, 0, 8'hFF, 1);
        for (int i = 0; i < 7; i++) cyc_a(0, 0, 1, 8'h00, 1);
        check("pre_sclr_usedw", bus_a.usedw, 9);
        cyc_a(1, 1, 0, 8'h77, 1);
        check("sclr_state", dut_a_pack(), pk(0, 0, 1, 0, 1, 0, 0, 8'hC6));
        cyc_a(0, 0, 0, 8'h00, 1);
        check("sclr_write_dropped", bus_a.usedw, 0);

        // Show-ahead instance
        cyc_b(1, 0, 8'hA5);
        check("sa_not_empty", bus_b.rdempty, 0);
        check("sa_q_fall", bus_b.q, 8'hA5);
        cyc_b(0, 0, 8'h00);
        check("sa_q_hold", bus_b.q, 8'hA5);
        cyc_b(0, 1, 8'h00);
        check("sa_pop_empty", bus_b.rdempty, 1);
        cyc_b(1, 0, 8'h5A);
        cyc_b(1, 0, 8'h3C);
        check("sa_head", bus_b.q, 8'h5A);
        check("sa_usedw", bus_b.usedw, 2);
        cyc_b(0, 1, 8'h00);
        check("sa_next", bus_b.q, 8'h3C);
        cyc_b(0, 1, 8'h00);
        check("sa_empty_again", bus_b.rdempty, 1);

        // Randomized traffic: write-heavy phase then read-heavy phase
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                w = ($urandom_range(0, 99) < 70);
                r = ($urandom_range(0, 99) < 40);
            end else begin
                w = ($urandom_range(0, 99) < 40);
                r = ($urandom_range(0, 99) < 70);
            end
            s = ($urandom_range(0, 99) == 0);
            cyc_a(s, w, r, 8'($urandom), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock successor to the dual-clock FIFO, for buffering within one clock domain, e.g. sample capture ahead of the USB/host packetiser.
- Generalised in width and depth; selectable normal or show-ahead read mode.
- Adds fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous clear.

Parameters:
- DATA_WIDTH, 8, width of data and q.
- ADDRESS_WIDTH, 4, log2 of depth; must be >= 2.
- FIFO_DEPTH, 1<<ADDRESS_WIDTH, derived; not to be overridden.
- SHOW_AHEAD, 0, 0 = normal (q valid 1 cycle after rdreq); 1 = first-word-fall-through.
- AF_THRESH, FIFO_DEPTH-2, almost_full asserts when usedw >= AF_THRESH; range 1..FIFO_DEPTH.
- AE_THRESH, 2, almost_empty asserts when usedw <= AE_THRESH; range 0..FIFO_DEPTH-1.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear; empties FIFO, clears error flags.
- data  in  DATA_WIDTH  write data.
- wrreq  in  1  write request.
- wrfull  out  1  FIFO holds FIFO_DEPTH words.
- q  out  DATA_WIDTH  read data.
- rdreq  in  1  read request (show-ahead: acknowledge of head word).
- rdempty  out  1  FIFO holds 0 words.
- usedw  out  ADDRESS_WIDTH+1  current word count, 0..FIFO_DEPTH.
- almost_full  out  1  usedw >= AF_THRESH.
- almost_empty  out  1  usedw <= AE_THRESH.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.

Behaviour:
- Reset (rst_n=0, async): pointers=0, usedw=0, rdempty=1, wrfull=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, q=0. Memory contents are not reset.
- Pointers: binary, ADDRESS_WIDTH+1 bits, with the extra bit as wrap flag. Address = low ADDRESS_WIDTH bits; wrap from FIFO_DEPTH-1 to 0 is natural.
- Write accepted iff wrreq & ~wrfull, judged on registered state at the edge. Accepted write stores data at wr_ptr and increments wr_ptr.
- Read accepted iff rdreq & ~rdempty, judged on registered state at the edge. Accepted read increments rd_ptr.
- Full + wrreq + rdreq: read accepted, write rejected, overflow set; next cycle usedw = FIFO_DEPTH-1.
- Empty + wrreq + rdreq: write accepted, read rejected, underflow set; next cycle usedw = 1.
- Otherwise simultaneous accepted read and write: usedw unchanged, both pointers advance.
- usedw next = usedw + wr_acc - rd_acc.
- wrfull, rdempty, almost_full and almost_empty are registered, computed from next usedw, so all update on the same edge as usedw. No combinational path from wrreq/rdreq to any flag.
- Normal mode (SHOW_AHEAD=0): q registered; q <= mem[rd_ptr] on an accepted read. q holds its value otherwise, including on a rejected read.
- Show-ahead (SHOW_AHEAD=1): q = mem[rd_addr] continuously while rdempty=0; the first written word appears on q the cycle after its write edge; rdreq pops it. q is don't-care while rdempty=1.
- overflow and underflow stay set until rst_n or sclr.
- sclr=1: on the next edge, pointers=0, usedw=0, flags as at reset, overflow=underflow=0. All requests that cycle are ignored; sclr takes priority over wrreq and rdreq. q is left unchanged.
- Illegal thresholds (outside stated ranges) are flagged by an elaboration-time check.

Decomposition:
- Shared header fifo_defs: SHOW_AHEAD mode constants (FIFO_MODE_NORMAL=0, FIFO_MODE_SHOWAHEAD=1) and the threshold range check macro, for reuse by later FIFO variants.
- One sub-module, sync_fifo_ram: simple dual-port memory, one write port and one read port, with parameter-selected registered or async read. The control logic (pointers, count, flags) stays in sync_fifo_flags.

Test Plan (DATA_WIDTH=8, ADDRESS_WIDTH=4, AF_THRESH=14, AE_THRESH=2):
- Reset mid-traffic: fill 5 words, pulse rst_n low between edges -> immediately usedw=0, rdempty=1, almost_empty=1, wrfull=0; the next read is rejected and sets underflow.
- Fill and drain, normal mode: write 0x00..0x0F on consecutive cycles.
  - almost_full rises the edge usedw reaches 14; wrfull rises at usedw=16.
  - A 17th write sets overflow; usedw stays 16.
  - Reading 16 times returns q 0x00..0x0F, each one cycle after its rdreq.
- Wrap-around: write/read 40 words with occupancy held at 3 -> data order preserved across pointer wrap; usedw constant at 3 with simultaneous reads and writes.
- Boundary simultaneity:
  - At full, assert wrreq+rdreq together -> usedw=15, overflow=1.
  - At empty, assert both together -> usedw=1, underflow=1, q unchanged.
- Show-ahead (SHOW_AHEAD=1): write 0xA5 -> the next cycle rdempty=0 and q=0xA5 with no rdreq; rdreq pops it -> rdempty=1.
- sclr with wrreq=1 at usedw=9, overflow=1 -> next cycle usedw=0, rdempty=1, overflow=0, and the write is dropped.
